// File: rtl/multi_clock_divider_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Optional start-phase support is enabled with CLKDIV_PHASE_EN.
package clkdiv_pkg;

  localparam int MIN_DIV = 2;

  function automatic int div_w(input int max_div);
    return $clog2(max_div + 1);
  endfunction

  // Internal divisor/phase width, wide enough for any MAX_DIV up to 65536
  localparam int CFG_W = div_w(65536);

  typedef struct packed {
    logic [CFG_W-1:0] div;
`ifdef CLKDIV_PHASE_EN
    logic [CFG_W-1:0] phase;
`endif
  } clkdiv_cfg_t;

endpackage

// File: rtl/multi_clock_divider_if.sv
// Configuration port of multi_clock_divider (valid/ready request plus error pulse).
// cfg_phase exists only when CLKDIV_PHASE_EN is defined.
interface multi_clock_divider_if #(
  parameter int N_CH    = 4,
  parameter int MAX_DIV = 1024
);
  localparam int DIV_W = clkdiv_pkg::div_w(MAX_DIV);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_err;
`ifdef CLKDIV_PHASE_EN
  logic [DIV_W-1:0] cfg_phase;

  modport master (output cfg_valid, cfg_ch, cfg_div, cfg_phase, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_phase, output cfg_ready, cfg_err);
`else
  modport master (output cfg_valid, cfg_ch, cfg_div, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, output cfg_ready, cfg_err);
`endif

endinterface

// File: rtl/multi_clock_divider_channel.sv
// One divider channel: period counter, single-entry shadow config, registered gen_clk/tick.
// With CLKDIV_PHASE_EN, sync loads the stored start phase instead of 0.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int DEFAULT_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        sync,
  input  logic        wr,
  input  clkdiv_cfg_t wr_cfg,
  output logic        pending,
  output logic        gen_clk,
  output logic        tick
);

  clkdiv_cfg_t      cur;
  clkdiv_cfg_t      shadow;
  clkdiv_cfg_t      nxt;
  logic [CFG_W-1:0] cnt;
  logic [CFG_W-1:0] cnt_nxt;
  logic [CFG_W-1:0] half;
  logic [CFG_W-1:0] start;
  logic             wrap;
  logic             apply;

  always_comb begin
    half  = (cur.div + CFG_W'(1)) >> 1;
    wrap  = en && (cnt == cur.div - CFG_W'(1));
    // Shadow is only promoted at a period boundary, on sync, or while idle
    apply = pending && (!en || sync || wrap);
    nxt   = apply ? shadow : cur;
`ifdef CLKDIV_PHASE_EN
    start = nxt.phase;
`else
    start = '0;
`endif
    if (!en)       cnt_nxt = '0;
    else if (sync) cnt_nxt = start;
    else if (wrap) cnt_nxt = '0;
    else           cnt_nxt = cnt + CFG_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      cur     <= '0;
      cur.div <= CFG_W'(DEFAULT_DIV);
      shadow  <= '0;
      pending <= 1'b0;
      gen_clk <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      cur     <= nxt;
      gen_clk <= en && (cnt < half);
      tick    <= en && (cnt == '0);
      if (apply) begin
        pending <= 1'b0;
      end else if (wr) begin
        shadow  <= wr_cfg;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_clock_divider.sv
// N-channel programmable clock divider: config decode, legality check, channel array.
// Define CLKDIV_PHASE_EN to enable per-channel start phase applied on sync.
module multi_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int MAX_DIV     = 1024,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       ch_en,
  input  logic                  sync,
  multi_clock_divider_if.slave  cfg,
  output logic [N_CH-1:0]       gen_clk,
  output logic [N_CH-1:0]       tick
);

  localparam int DIV_W = div_w(MAX_DIV);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CH_W:0] N_CH_V = (CH_W + 1)'(N_CH);

  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] wr;
  logic            ch_ok;
  logic            legal;
  logic            hs;
  clkdiv_cfg_t     wr_cfg;

  always_comb begin
    ch_ok = {1'b0, cfg.cfg_ch} < N_CH_V;
    legal = ch_ok && (cfg.cfg_div >= DIV_W'(MIN_DIV)) && (cfg.cfg_div <= DIV_W'(MAX_DIV));
    wr_cfg     = '0;
    wr_cfg.div = CFG_W'(cfg.cfg_div);
`ifdef CLKDIV_PHASE_EN
    legal        = legal && (cfg.cfg_phase < cfg.cfg_div);
    wr_cfg.phase = CFG_W'(cfg.cfg_phase);
`endif
  end

  // Out-of-range channels are always ready so the request can be dropped with an error
  assign cfg.cfg_ready = ch_ok ? !pending[cfg.cfg_ch] : 1'b1;
  assign hs            = cfg.cfg_valid && cfg.cfg_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg.cfg_err <= 1'b0;
    else     cfg.cfg_err <= hs && !legal;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign wr[i] = hs && legal && (cfg.cfg_ch == CH_W'(i));

    clkdiv_channel #(
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (ch_en[i]),
      .sync   (sync),
      .wr     (wr[i]),
      .wr_cfg (wr_cfg),
      .pending(pending[i]),
      .gen_clk(gen_clk[i]),
      .tick   (tick[i])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider; phase checks run when CLKDIV_PHASE_EN is defined.
module tb_multi_clock_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ch_en;
  logic       sync;
  logic [3:0] gen_clk;
  logic [3:0] tick;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [31:0] ga, ta, gb, tb_;

  multi_clock_divider_if #(.N_CH(4), .MAX_DIV(1024)) cfg_if ();

  multi_clock_divider #(
    .N_CH       (4),
    .MAX_DIV    (1024),
    .DEFAULT_DIV(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ch_en  (ch_en),
    .sync   (sync),
    .cfg    (cfg_if),
    .gen_clk(gen_clk),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  // Samples channels a and b after each of the next n rising edges, oldest sample in the MSB
  task automatic run(input int a, input int b, input int n,
                     output logic [31:0] g_a, output logic [31:0] t_a,
                     output logic [31:0] g_b, output logic [31:0] t_b);
    g_a = '0; t_a = '0; g_b = '0; t_b = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      g_a = {g_a[30:0], gen_clk[a]};
      t_a = {t_a[30:0], tick[a]};
      g_b = {g_b[30:0], gen_clk[b]};
      t_b = {t_b[30:0], tick[b]};
    end
  endtask

  // One-cycle config request issued at a falling edge; returns at the next falling edge
  task automatic cfg_write(input string tag, input int ch, input int div, input int phase,
                           input logic exp_err);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'(ch);
    cfg_if.cfg_div   = 11'(div);
`ifdef CLKDIV_PHASE_EN
    cfg_if.cfg_phase = 11'(phase);
`endif
    check({tag, " ready"}, 32'(cfg_if.cfg_ready), 32'd1);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    check({tag, " err"}, 32'(cfg_if.cfg_err), 32'(exp_err));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ch_en = '0; sync = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_div = '0;
`ifdef CLKDIV_PHASE_EN
    cfg_if.cfg_phase = '0;
`endif
    repeat (2) @(negedge clk);
    check("rst gen_clk", 32'(gen_clk), 32'd0);
    check("rst tick", 32'(tick), 32'd0);
    check("rst cfg_err", 32'(cfg_if.cfg_err), 32'd0);
    check("rst cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Default D=4 on ch0/ch1
    ch_en = 4'b0011;
    run(0, 1, 8, ga, ta, gb, tb_);
    check("d4 gen0", ga, 32'b11001100);
    check("d4 tick0", ta, 32'b10001000);
    check("d4 gen1", gb, 32'b11001100);

    // D=5 on ch1, applied at the next wrap with no runt
    cfg_write("d5", 1, 5, 0, 1'b0);
    check("d5 ready pending", 32'(cfg_if.cfg_ready), 32'd0);
    run(1, 0, 9, ga, ta, gb, tb_);
    check("d5 gen1", ga, 32'b100111001);
    check("d5 tick1", ta, 32'b000100001);
    check("d5 ready applied", 32'(cfg_if.cfg_ready), 32'd1);

    // Illegal divisors
    cfg_write("div1", 0, 1, 0, 1'b1);
    @(negedge clk);
    check("div1 err clear", 32'(cfg_if.cfg_err), 32'd0);
    check("div1 no pending", 32'(cfg_if.cfg_ready), 32'd1);
    cfg_write("div1025", 0, 1025, 0, 1'b1);
    @(negedge clk);
    check("div1025 err clear", 32'(cfg_if.cfg_err), 32'd0);

    // ch1 D=8, then sync mid-period aligns both channels
    cfg_write("d8", 1, 8, 0, 1'b0);
    repeat (6) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    run(0, 1, 8, ga, ta, gb, tb_);
    check("sync gen0", ga, 32'b11001100);
    check("sync tick0", ta, 32'b10001000);
    check("sync gen1", gb, 32'b11110000);
    check("sync tick1", tb_, 32'b10000000);

    // Reset during a high phase with a pending update on ch0
    cfg_write("pre-rst", 0, 6, 0, 1'b0);
    check("pre-rst ready", 32'(cfg_if.cfg_ready), 32'd0);
    check("pre-rst gen0 high", 32'(gen_clk[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst async gen_clk", 32'(gen_clk), 32'd0);
    check("rst async tick", 32'(tick), 32'd0);
    check("rst pending lost", 32'(cfg_if.cfg_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run(0, 1, 8, ga, ta, gb, tb_);
    check("post-rst gen0", ga, 32'b11001100);
    check("post-rst tick0", ta, 32'b10001000);
    check("post-rst gen1", gb, 32'b11001100);

    // Disabling truncates; a disabled channel applies its shadow on the next edge
    ch_en = 4'b0010;
    @(negedge clk);
    check("dis gen0", 32'(gen_clk[0]), 32'd0);
    cfg_write("dis d2", 0, 2, 0, 1'b0);
    check("dis pending", 32'(cfg_if.cfg_ready), 32'd0);
    @(negedge clk);
    check("dis applied", 32'(cfg_if.cfg_ready), 32'd1);
    ch_en = 4'b0011;
    run(0, 0, 8, ga, ta, gb, tb_);
    check("d2 gen0", ga, 32'b10101010);
    check("d2 tick0", ta, 32'b10101010);

`ifdef CLKDIV_PHASE_EN
    cfg_write("ph ch0", 0, 8, 0, 1'b0);
    cfg_write("ph ch1", 1, 8, 4, 1'b0);
    repeat (10) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    run(0, 1, 8, ga, ta, gb, tb_);
    check("ph gen0", ga, 32'b11110000);
    check("ph tick0", ta, 32'b10000000);
    check("ph gen1", gb, 32'b00001111);
    check("ph tick1", tb_, 32'b00001000);
    cfg_write("ph8", 1, 8, 8, 1'b1);
    check("ph8 no pending", 32'(cfg_if.cfg_ready), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
